rps_match_ctrl: RTL and testbench

RPS_MATCH_CTRL -- requirements
Module: rps_match_ctrl

---
 rtl/rps_pkg.sv | 27 ++
 rtl/rps_judge.sv | 22 ++
 rtl/rps_match_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rps_match_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors match controller: moves,
// round results, match winner codes and FSM states.
package rps_pkg;

  localparam logic [1:0] MV_ROCK     = 2'b00;
  localparam logic [1:0] MV_PAPER    = 2'b01;
  localparam logic [1:0] MV_SCISSORS = 2'b10;
  localparam logic [1:0] MV_ILLEGAL  = 2'b11;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_P1      = 2'b01;
  localparam logic [1:0] RES_P2      = 2'b10;
  localparam logic [1:0] RES_TIE     = 2'b11;

  localparam logic [1:0] WIN_DRAW    = 2'b00;
  localparam logic [1:0] WIN_P1      = 2'b01;
  localparam logic [1:0] WIN_P2      = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_JUDGE   = 3'd2,
    ST_REPORT  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: paper beats rock, scissors beats paper,
// rock beats scissors, equal moves tie. Inputs are always legal moves.
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] i_p1,
  input  logic [1:0] i_p2,
  output logic [1:0] o_result
);

  always_comb begin
    o_result = RES_P2;
    if (i_p1 == i_p2) begin
      o_result = RES_TIE;
    end else if ((i_p1 == MV_PAPER    && i_p2 == MV_ROCK)  ||
                 (i_p1 == MV_SCISSORS && i_p2 == MV_PAPER) ||
                 (i_p1 == MV_ROCK     && i_p2 == MV_SCISSORS)) begin
      o_result = RES_P1;
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller: collects moves, judges rounds, keeps
// score. Optional collect timeout enabled by defining RPS_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// COLLECT | accepting one legal move per player
// JUDGE   | scoring the held moves
// REPORT  | one-cycle result strobe, decide next round or end
// DONE    | match over, winner held, waiting for start
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int WIN_TARGET     = 3,
  parameter int MAX_ROUNDS     = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [1:0] i_p1_move,
  input  logic [1:0] i_p2_move,
  input  logic       i_p1_valid,
  input  logic       i_p2_valid,
  output logic       o_p1_ack,
  output logic       o_p2_ack,
  output logic       o_p1_illegal,
  output logic       o_p2_illegal,
  output logic       o_busy,
  output logic [1:0] o_round_result,
  output logic       o_result_valid,
  output logic [3:0] o_p1_score,
  output logic [3:0] o_p2_score,
  output logic [3:0] o_round_cnt,
  output logic       o_match_done,
  output logic [1:0] o_match_winner
);

  state_e     r_state, w_next;
  logic       r_p1_held, r_p2_held;
  logic [1:0] r_p1_move, r_p2_move;
  logic [3:0] r_p1_score, r_p2_score, r_round_cnt;
  logic [1:0] r_result, r_winner;
  logic       w_start_ok, w_both, w_match_over, w_to_hit, w_forfeit;
  logic [1:0] w_judge_res, w_round_res;

  rps_judge u_judge (
    .i_p1     (r_p1_move),
    .i_p2     (r_p2_move),
    .o_result (w_judge_res)
  );

  // A forfeited round goes to whoever managed to commit a move.
  assign w_round_res  = w_forfeit ? (r_p1_held ? RES_P1 : RES_P2) : w_judge_res;
  assign w_match_over = (r_p1_score == 4'(WIN_TARGET)) || (r_p2_score == 4'(WIN_TARGET)) ||
                        (r_round_cnt == 4'(MAX_ROUNDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_start_ok     = 1'b0;
    w_both         = 1'b0;
    o_p1_ack       = 1'b0;
    o_p2_ack       = 1'b0;
    o_p1_illegal   = 1'b0;
    o_p2_illegal   = 1'b0;
    o_busy         = 1'b0;
    o_result_valid = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_start_ok = 1'b1;
          w_next     = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        o_busy       = 1'b1;
        o_p1_ack     = i_p1_valid && !r_p1_held && (i_p1_move != MV_ILLEGAL);
        o_p2_ack     = i_p2_valid && !r_p2_held && (i_p2_move != MV_ILLEGAL);
        o_p1_illegal = i_p1_valid && !r_p1_held && (i_p1_move == MV_ILLEGAL);
        o_p2_illegal = i_p2_valid && !r_p2_held && (i_p2_move == MV_ILLEGAL);
        w_both       = (r_p1_held || o_p1_ack) && (r_p2_held || o_p2_ack);
        if (w_both || w_to_hit) w_next = ST_JUDGE;
      end
      ST_JUDGE: begin
        o_busy = 1'b1;
        w_next = ST_REPORT;
      end
      ST_REPORT: begin
        o_busy         = 1'b1;
        o_result_valid = 1'b1;
        w_next         = w_match_over ? ST_DONE : ST_COLLECT;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_held   <= 1'b0;
      r_p2_held   <= 1'b0;
      r_p1_move   <= MV_ROCK;
      r_p2_move   <= MV_ROCK;
      r_p1_score  <= '0;
      r_p2_score  <= '0;
      r_round_cnt <= '0;
      r_result    <= RES_NONE;
      r_winner    <= WIN_DRAW;
    end else begin
      if (w_start_ok) begin
        r_p1_held   <= 1'b0;
        r_p2_held   <= 1'b0;
        r_p1_score  <= '0;
        r_p2_score  <= '0;
        r_round_cnt <= '0;
        r_winner    <= WIN_DRAW;
      end
      if (o_p1_ack) begin
        r_p1_move <= i_p1_move;
        r_p1_held <= 1'b1;
      end
      if (o_p2_ack) begin
        r_p2_move <= i_p2_move;
        r_p2_held <= 1'b1;
      end
      // Score in JUDGE so REPORT already shows the updated totals.
      if (r_state == ST_JUDGE) begin
        r_result    <= w_round_res;
        r_round_cnt <= r_round_cnt + 4'd1;
        if (w_round_res == RES_P1) r_p1_score <= r_p1_score + 4'd1;
        if (w_round_res == RES_P2) r_p2_score <= r_p2_score + 4'd1;
      end
      if (r_state == ST_REPORT) begin
        r_p1_held <= 1'b0;
        r_p2_held <= 1'b0;
        if (w_match_over) begin
          if (r_p1_score > r_p2_score)      r_winner <= WIN_P1;
          else if (r_p2_score > r_p1_score) r_winner <= WIN_P2;
          else                              r_winner <= WIN_DRAW;
        end
      end
    end
  end

`ifdef RPS_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;
  logic            r_forfeit;
  logic            w_one_held;

  assign w_one_held = (r_state == ST_COLLECT) && (r_p1_held ^ r_p2_held);
  assign w_to_hit   = w_one_held && (r_to_cnt == '0);
  assign w_forfeit  = r_forfeit;

  // Reloads whenever fewer or more than one move is held, so each round starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt  <= TO_W'(TIMEOUT_CYCLES - 1);
      r_forfeit <= 1'b0;
    end else begin
      if (!w_one_held)          r_to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
      else if (r_to_cnt != '0)  r_to_cnt <= r_to_cnt - 1'b1;
      if (r_state == ST_COLLECT && w_next == ST_JUDGE) r_forfeit <= !w_both;
    end
  end
`else
  assign w_to_hit  = 1'b0;
  assign w_forfeit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  assign o_round_result = r_result;
  assign o_p1_score     = r_p1_score;
  assign o_p2_score     = r_p2_score;
  assign o_round_cnt    = r_round_cnt;
  assign o_match_done   = (r_state == ST_DONE);
  assign o_match_winner = r_winner;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Directed bench for rps_match_ctrl with default parameters.
module tb_rps_match_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] p1_move = 2'b00, p2_move = 2'b00;
  logic       p1_valid = 1'b0, p2_valid = 1'b0;
  logic       p1_ack, p2_ack, p1_ill, p2_ill, busy, rv, done;
  logic [1:0] rr, winner;
  logic [3:0] s1, s2, rc;

  int n_checks = 0;
  int n_pass   = 0;

  rps_match_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (start),
    .i_p1_move      (p1_move),
    .i_p2_move      (p2_move),
    .i_p1_valid     (p1_valid),
    .i_p2_valid     (p2_valid),
    .o_p1_ack       (p1_ack),
    .o_p2_ack       (p2_ack),
    .o_p1_illegal   (p1_ill),
    .o_p2_illegal   (p2_ill),
    .o_busy         (busy),
    .o_round_result (rr),
    .o_result_valid (rv),
    .o_p1_score     (s1),
    .o_p2_score     (s2),
    .o_round_cnt    (rc),
    .o_match_done   (done),
    .o_match_winner (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int all_outs();
    return int'({p1_ack, p2_ack, p1_ill, p2_ill, busy, rr, rv, s1, s2, rc, done, winner});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_rc0"}, rc, 0);
  endtask

  // Both players move together; REPORT lands two edges later.
  task automatic play(input logic [1:0] m1, input logic [1:0] m2, input int res,
                      input int e1, input int e2, input int erc, input string tag);
    p1_move = m1; p2_move = m2; p1_valid = 1'b1; p2_valid = 1'b1;
    #1;
    chk({tag, "_acks"}, {p1_ack, p2_ack}, 3);
    step();
    p1_valid = 1'b0; p2_valid = 1'b0;
    #1;
    chk({tag, "_judge_rv"}, rv, 0);
    step();
    chk({tag, "_rv"}, rv, 1);
    chk({tag, "_res"}, rr, res);
    chk({tag, "_s1"}, s1, e1);
    chk({tag, "_s2"}, s2, e2);
    chk({tag, "_rc"}, rc, erc);
    step();
  endtask

  initial begin
    #12;
    chk("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    do_start("start1");

    play(2'b00, 2'b01, 2, 0, 1, 1, "r1");

    // p1 holds valid for several cycles; only one ack
    p1_move = 2'b10; p1_valid = 1'b1;
    #1;
    chk("hold_ack0", p1_ack, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_noack", p1_ack, 0);
    end
    step();
    p2_move = 2'b01; p2_valid = 1'b1;
    #1;
    chk("hold_p1_noack", p1_ack, 0);
    chk("hold_p2_ack", p2_ack, 1);
    step();
    p1_valid = 1'b0; p2_valid = 1'b0;
    step();
    chk("r2_rv", rv, 1);
    chk("r2_res", rr, 1);
    chk("r2_s1", s1, 1);
    chk("r2_rc", rc, 2);
    step();

    // illegal move from p2, then a legal one
    p2_move = 2'b11; p2_valid = 1'b1;
    #1;
    chk("ill_pulse", p2_ill, 1);
    chk("ill_noack", p2_ack, 0);
    step();
    p2_valid = 1'b0;
    #1;
    chk("ill_gone", p2_ill, 0);
    chk("ill_busy", busy, 1);
    p2_move = 2'b00; p2_valid = 1'b1;
    #1;
    chk("ill_then_ack", p2_ack, 1);
    step();
    p2_valid = 1'b0; p1_move = 2'b00; p1_valid = 1'b1;
    #1;
    chk("r3_p1_ack", p1_ack, 1);
    chk("r3_rv_pre", rv, 0);
    step();
    p1_valid = 1'b0;
    step();
    chk("r3_res", rr, 3);
    chk("r3_s1", s1, 1);
    chk("r3_s2", s2, 1);
    chk("r3_rc", rc, 3);
    step();

    play(2'b00, 2'b10, 1, 2, 1, 4, "r4");
    play(2'b01, 2'b00, 1, 3, 1, 5, "r5");
    chk("m1_done", done, 1);
    chk("m1_winner", winner, 1);
    chk("m1_busy", busy, 0);
    p1_move = 2'b00; p1_valid = 1'b1;
    #1;
    chk("done_noack", p1_ack, 0);
    p1_valid = 1'b0;

    do_start("start2");
    chk("start2_s1", s1, 0);
    chk("start2_s2", s2, 0);
    chk("start2_done", done, 0);
    chk("start2_winner", winner, 0);
    play(2'b10, 2'b01, 1, 1, 0, 1, "m2r1");
    play(2'b00, 2'b10, 1, 2, 0, 2, "m2r2");
    play(2'b01, 2'b00, 1, 3, 0, 3, "m2r3");
    chk("m2_done", done, 1);
    chk("m2_winner", winner, 1);

    // eight ties then a p2 win on the round limit
    do_start("start3");
    for (int i = 1; i <= 8; i++) play(2'b01, 2'b01, 3, 0, 0, i, "tie");
    chk("m3_notdone", done, 0);
    chk("m3_busy", busy, 1);
    play(2'b00, 2'b01, 2, 0, 1, 9, "m3r9");
    chk("m3_done", done, 1);
    chk("m3_winner", winner, 2);

    do_start("start4");
    for (int i = 1; i <= 9; i++) play(2'b10, 2'b10, 3, 0, 0, i, "draw");
    chk("m4_done", done, 1);
    chk("m4_winner", winner, 0);

    // reset between p1 ack and p2 move
    do_start("start5");
    p1_move = 2'b00; p1_valid = 1'b1;
    #1;
    chk("mid_p1_ack", p1_ack, 1);
    step();
    p1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", all_outs(), 0);
    #2;
    rst_n = 1'b1;
    do_start("start6");
    p1_move = 2'b01; p1_valid = 1'b1;
    #1;
    chk("post_reset_ack", p1_ack, 1);
    p1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
